// File: rtl/score_keeper_pkg.sv
// rtl/score_keeper_pkg.sv - shared types and constants for the score keeper
package score_keeper_pkg;

   typedef enum logic [1:0] {
      ST_PLAY  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_OVER  = 2'd2
   } state_e;

   typedef logic [3:0] bcd_t;

   localparam int unsigned PTS_NORMAL     = 1;
   localparam int unsigned PTS_GOLD       = 3;
   localparam int unsigned COMBO_BONUS_AT = 5;
   localparam int unsigned COMBO_SAT      = 7;
   localparam int unsigned SCORE_SAT      = 99;
   localparam logic [3:0]  PENDING_SAT    = 4'd15;

   // Packs a 0..99 decimal value as {tens, ones} BCD.
   function automatic logic [7:0] to_bcd(input int unsigned v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/score_keeper_bcd2_counter.sv
// rtl/score_keeper_bcd2_counter.sv - two-digit BCD incrementer saturating at MAX_VAL
module bcd2_counter
   import score_keeper_pkg::*;
#(
   parameter int unsigned MAX_VAL = SCORE_SAT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output bcd_t tens,
   output bcd_t ones
);

   localparam logic [7:0] MAX_BCD = to_bcd(MAX_VAL);

   bcd_t tens_q, tens_d;
   bcd_t ones_q, ones_d;

   // Next value: clear wins, otherwise step by one with ones->tens carry, holding at the ceiling.
   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (clear) begin
         tens_d = 4'd0;
         ones_d = 4'd0;
      end else if (inc && ({tens_q, ones_q} != MAX_BCD)) begin
         if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   // Digit registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         tens_q <= 4'd0;
         ones_q <= 4'd0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens = tens_q;
   assign ones = ones_q;

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - BCD score accumulator with combo bonus, high score and game sequencing
module score_keeper
   import score_keeper_pkg::*;
#(
   parameter int unsigned NORMAL_PTS = PTS_NORMAL,
   parameter int unsigned GOLD_PTS   = PTS_GOLD,
   parameter int unsigned BONUS_AT   = COMBO_BONUS_AT,
   parameter int unsigned COMBO_MAX  = COMBO_SAT,
   parameter int unsigned SCORE_MAX  = SCORE_SAT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       time_up,
   input  logic       catch_evt,
   input  logic       miss_evt,
   input  logic       coin_type,
   output logic [3:0] score_tens,
   output logic [3:0] score_ones,
   output logic [3:0] hi_tens,
   output logic [3:0] hi_ones,
   output logic [2:0] combo,
   output logic       busy,
   output logic       game_over,
   output logic       new_record
);

   state_e     state_q, state_d;
   logic [2:0] combo_q, combo_d;
   logic [3:0] pending_q, pending_d;
   bcd_t       hi_tens_q, hi_tens_d;
   bcd_t       hi_ones_q, hi_ones_d;
   logic       new_record_q, new_record_d;
   logic       score_clear;
   bcd_t       sc_tens, sc_ones;

   logic       in_play, take_catch, take_miss, draining, bonus;
   logic [2:0] combo_nx;
   logic [4:0] base_pts, pts, pend_sum;
   logic [3:0] pending_nx;

   // Score digits; the increment engine feeds one point per cycle from pending.
   bcd2_counter #(.MAX_VAL(SCORE_MAX)) u_score (
      .clk   (clk),
      .reset (reset),
      .clear (score_clear),
      .inc   (draining),
      .tens  (sc_tens),
      .ones  (sc_ones)
   );

   // Event qualification and point arithmetic; a simultaneous miss forfeits the bonus.
   always_comb begin
      in_play    = (state_q == ST_PLAY);
      take_catch = in_play && catch_evt;
      take_miss  = in_play && miss_evt;
      draining   = (pending_q != 4'd0);
      combo_nx   = (combo_q >= 3'(COMBO_MAX)) ? 3'(COMBO_MAX) : combo_q + 3'd1;
      base_pts   = coin_type ? 5'(GOLD_PTS) : 5'(NORMAL_PTS);
      bonus      = (combo_nx >= 3'(BONUS_AT)) && !miss_evt;
      pts        = take_catch ? base_pts + {4'd0, bonus} : 5'd0;
      pend_sum   = {1'b0, pending_q} + pts - {4'd0, draining};
      pending_nx = (pend_sum > {1'b0, PENDING_SAT}) ? PENDING_SAT : pend_sum[3:0];
   end

   // Game sequencing: PLAY accepts events, DRAIN flushes pending, OVER waits for start.
   always_comb begin
      state_d      = state_q;
      combo_d      = combo_q;
      pending_d    = pending_nx;
      hi_tens_d    = hi_tens_q;
      hi_ones_d    = hi_ones_q;
      new_record_d = new_record_q;
      score_clear  = 1'b0;
      case (state_q)
         ST_PLAY: begin
            if (take_miss) begin
               combo_d = 3'd0;
            end else if (take_catch) begin
               combo_d = combo_nx;
            end
            if (time_up) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!draining) begin
               state_d = ST_OVER;
               if ({sc_tens, sc_ones} > {hi_tens_q, hi_ones_q}) begin
                  hi_tens_d    = sc_tens;
                  hi_ones_d    = sc_ones;
                  new_record_d = 1'b1;
               end else begin
                  new_record_d = 1'b0;
               end
            end
         end
         ST_OVER: begin
            if (start && !time_up) begin
               state_d      = ST_PLAY;
               combo_d      = 3'd0;
               pending_d    = 4'd0;
               new_record_d = 1'b0;
               score_clear  = 1'b1;
            end
         end
         default: begin
            state_d = ST_PLAY;
         end
      endcase
   end

   // State, combo, pending and high-score registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_PLAY;
         combo_q      <= 3'd0;
         pending_q    <= 4'd0;
         hi_tens_q    <= 4'd0;
         hi_ones_q    <= 4'd0;
         new_record_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         combo_q      <= combo_d;
         pending_q    <= pending_d;
         hi_tens_q    <= hi_tens_d;
         hi_ones_q    <= hi_ones_d;
         new_record_q <= new_record_d;
      end
   end

   assign score_tens = sc_tens;
   assign score_ones = sc_ones;
   assign hi_tens    = hi_tens_q;
   assign hi_ones    = hi_ones_q;
   assign combo      = combo_q;
   assign busy       = draining;
   assign game_over  = (state_q == ST_OVER);
   assign new_record = new_record_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed self-checking bench for score_keeper
module tb_score_keeper;

   logic       clk = 1'b0;
   logic       reset, start, time_up, catch_evt, miss_evt, coin_type;
   logic [3:0] score_tens, score_ones, hi_tens, hi_ones;
   logic [2:0] combo;
   logic       busy, game_over, new_record;
   logic [7:0] score, hi;
   int         errors = 0;
   int         checks = 0;

   assign score = {score_tens, score_ones};
   assign hi    = {hi_tens, hi_ones};

   always #5 clk = ~clk;

   score_keeper dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .time_up    (time_up),
      .catch_evt  (catch_evt),
      .miss_evt   (miss_evt),
      .coin_type  (coin_type),
      .score_tens (score_tens),
      .score_ones (score_ones),
      .hi_tens    (hi_tens),
      .hi_ones    (hi_ones),
      .combo      (combo),
      .busy       (busy),
      .game_over  (game_over),
      .new_record (new_record)
   );

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; time_up = 1'b0;
      catch_evt = 1'b0; miss_evt = 1'b0; coin_type = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse(input logic c, input logic gold, input logic m);
      catch_evt = c; coin_type = gold; miss_evt = m;
      @(negedge clk);
      catch_evt = 1'b0; coin_type = 1'b0; miss_evt = 1'b0;
   endtask

   task automatic settle();
      for (int i = 0; i < 40 && busy !== 1'b0; i++) @(negedge clk);
      if (busy !== 1'b0) begin
         $display("FAIL settle_timeout busy=%b exp=0", busy); errors++;
      end
      checks++;
   endtask

   task automatic test_reset();
      do_reset();
      repeat (5) @(negedge clk);
      if (score !== 8'h00) begin $display("FAIL reset_score got=%h exp=00", score); errors++; end checks++;
      if (hi !== 8'h00) begin $display("FAIL reset_hi got=%h exp=00", hi); errors++; end checks++;
      if (combo !== 3'd0) begin $display("FAIL reset_combo got=%0d exp=0", combo); errors++; end checks++;
      if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); errors++; end checks++;
      if (game_over !== 1'b0) begin $display("FAIL reset_game_over got=%b exp=0", game_over); errors++; end checks++;
      if (new_record !== 1'b0) begin $display("FAIL reset_new_record got=%b exp=0", new_record); errors++; end checks++;
   endtask

   task automatic test_spaced_catches();
      logic [7:0] exp;
      do_reset();
      for (int n = 1; n <= 3; n++) begin
         pulse(1'b1, 1'b0, 1'b0);
         exp = 8'(n - 1);
         if (busy !== 1'b1) begin $display("FAIL spaced_busy n=%0d got=%b exp=1", n, busy); errors++; end checks++;
         if (score !== exp) begin $display("FAIL spaced_early n=%0d got=%h exp=%h", n, score, exp); errors++; end checks++;
         @(negedge clk);
         exp = 8'(n);
         if (score !== exp) begin $display("FAIL spaced_score n=%0d got=%h exp=%h", n, score, exp); errors++; end checks++;
         if (busy !== 1'b0) begin $display("FAIL spaced_idle n=%0d got=%b exp=0", n, busy); errors++; end checks++;
         repeat (2) @(negedge clk);
      end
      if (combo !== 3'd3) begin $display("FAIL spaced_combo got=%0d exp=3", combo); errors++; end checks++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_sc [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      do_reset();
      catch_evt = 1'b1; coin_type = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) begin $display("FAIL b2b_busy i=%0d got=%b exp=1", i, busy); errors++; end checks++;
         if (score !== exp_sc[i]) begin $display("FAIL b2b_score i=%0d got=%h exp=%h", i, score, exp_sc[i]); errors++; end checks++;
      end
      catch_evt = 1'b0;
      @(negedge clk);
      if (score !== 8'h05 || busy !== 1'b1) begin $display("FAIL b2b_tail score=%h busy=%b exp=05/1", score, busy); errors++; end checks++;
      @(negedge clk);
      if (score !== 8'h06) begin $display("FAIL b2b_final got=%h exp=06", score); errors++; end checks++;
      if (busy !== 1'b0) begin $display("FAIL b2b_done got=%b exp=0", busy); errors++; end checks++;
      if (combo !== 3'd5) begin $display("FAIL b2b_combo got=%0d exp=5", combo); errors++; end checks++;
   endtask

   task automatic test_saturate();
      int s_exp, c_exp, p;
      logic gold;
      logic [7:0] bcd_exp;
      do_reset();
      s_exp = 0; c_exp = 0;
      // 25 gold catches then one normal: 3+3+3+3 + 21*4 + 2 = 98
      for (int n = 0; n < 26; n++) begin
         gold = (n < 25);
         pulse(1'b1, gold, 1'b0);
         settle();
         c_exp = (c_exp >= 7) ? 7 : c_exp + 1;
         p = (gold ? 3 : 1) + ((c_exp >= 5) ? 1 : 0);
         s_exp = (s_exp + p > 99) ? 99 : s_exp + p;
         bcd_exp = {4'(s_exp / 10), 4'(s_exp % 10)};
         if (score !== bcd_exp) begin $display("FAIL climb_score n=%0d got=%h exp=%h", n, score, bcd_exp); errors++; end checks++;
      end
      if (score !== 8'h98) begin $display("FAIL climb_98 got=%h exp=98", score); errors++; end checks++;
      if (combo !== 3'd7) begin $display("FAIL combo_sat got=%0d exp=7", combo); errors++; end checks++;
      pulse(1'b0, 1'b0, 1'b1);
      if (combo !== 3'd0) begin $display("FAIL miss_combo got=%0d exp=0", combo); errors++; end checks++;
      pulse(1'b1, 1'b1, 1'b0);
      if (score !== 8'h98 || busy !== 1'b1) begin $display("FAIL sat_load score=%h busy=%b exp=98/1", score, busy); errors++; end checks++;
      @(negedge clk);
      if (score !== 8'h99 || busy !== 1'b1) begin $display("FAIL sat_c1 score=%h busy=%b exp=99/1", score, busy); errors++; end checks++;
      @(negedge clk);
      if (score !== 8'h99 || busy !== 1'b1) begin $display("FAIL sat_c2 score=%h busy=%b exp=99/1", score, busy); errors++; end checks++;
      @(negedge clk);
      if (score !== 8'h99 || busy !== 1'b0) begin $display("FAIL sat_c3 score=%h busy=%b exp=99/0", score, busy); errors++; end checks++;
      repeat (2) @(negedge clk);
      if (score !== 8'h99) begin $display("FAIL sat_hold got=%h exp=99", score); errors++; end checks++;
   endtask

   task automatic test_catch_miss();
      do_reset();
      for (int n = 0; n < 4; n++) begin
         pulse(1'b1, 1'b0, 1'b0);
         settle();
      end
      if (score !== 8'h04 || combo !== 3'd4) begin $display("FAIL cm_pre score=%h combo=%0d exp=04/4", score, combo); errors++; end checks++;
      pulse(1'b1, 1'b0, 1'b1);
      if (combo !== 3'd0) begin $display("FAIL cm_combo got=%0d exp=0", combo); errors++; end checks++;
      @(negedge clk);
      if (score !== 8'h05) begin $display("FAIL cm_score got=%h exp=05", score); errors++; end checks++;
      if (busy !== 1'b0) begin $display("FAIL cm_busy got=%b exp=0", busy); errors++; end checks++;
   endtask

   task automatic test_drain_over();
      do_reset();
      for (int n = 0; n < 3; n++) begin pulse(1'b1, 1'b1, 1'b0); settle(); end
      pulse(1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b0, 1'b0); settle();
      pulse(1'b0, 1'b0, 1'b1);
      if (score !== 8'h10) begin $display("FAIL do_pre got=%h exp=10", score); errors++; end checks++;
      pulse(1'b1, 1'b1, 1'b0);
      if (busy !== 1'b1 || score !== 8'h10) begin $display("FAIL do_load busy=%b score=%h exp=1/10", busy, score); errors++; end checks++;
      time_up = 1'b1;
      @(negedge clk);
      if (score !== 8'h11 || game_over !== 1'b0) begin $display("FAIL do_d1 score=%h go=%b exp=11/0", score, game_over); errors++; end checks++;
      catch_evt = 1'b1; coin_type = 1'b1;
      @(negedge clk);
      catch_evt = 1'b0; coin_type = 1'b0;
      if (score !== 8'h12 || busy !== 1'b1) begin $display("FAIL do_d2 score=%h busy=%b exp=12/1", score, busy); errors++; end checks++;
      @(negedge clk);
      if (score !== 8'h13 || busy !== 1'b0 || game_over !== 1'b0) begin $display("FAIL do_d3 score=%h busy=%b go=%b exp=13/0/0", score, busy, game_over); errors++; end checks++;
      if (combo !== 3'd1) begin $display("FAIL do_ignore_combo got=%0d exp=1", combo); errors++; end checks++;
      @(negedge clk);
      if (game_over !== 1'b1) begin $display("FAIL do_over got=%b exp=1", game_over); errors++; end checks++;
      if (hi !== 8'h13) begin $display("FAIL do_hi got=%h exp=13", hi); errors++; end checks++;
      if (new_record !== 1'b1) begin $display("FAIL do_record got=%b exp=1", new_record); errors++; end checks++;
      catch_evt = 1'b1; start = 1'b1;
      @(negedge clk);
      catch_evt = 1'b0; start = 1'b0;
      if (game_over !== 1'b1 || score !== 8'h13 || busy !== 1'b0) begin $display("FAIL do_start_blocked go=%b score=%h busy=%b exp=1/13/0", game_over, score, busy); errors++; end checks++;
      time_up = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (game_over !== 1'b0) begin $display("FAIL do_restart_go got=%b exp=0", game_over); errors++; end checks++;
      if (score !== 8'h00) begin $display("FAIL do_restart_score got=%h exp=00", score); errors++; end checks++;
      if (hi !== 8'h13) begin $display("FAIL do_restart_hi got=%h exp=13", hi); errors++; end checks++;
      if (new_record !== 1'b0 || combo !== 3'd0) begin $display("FAIL do_restart_clr rec=%b combo=%0d exp=0/0", new_record, combo); errors++; end checks++;
   endtask

   task automatic test_no_record_and_reset();
      for (int n = 0; n < 3; n++) begin pulse(1'b1, 1'b0, 1'b0); settle(); end
      time_up = 1'b1;
      for (int i = 0; i < 10 && game_over !== 1'b1; i++) @(negedge clk);
      if (game_over !== 1'b1) begin $display("FAIL nr_over got=%b exp=1", game_over); errors++; end checks++;
      if (hi !== 8'h13 || score !== 8'h03) begin $display("FAIL nr_hi hi=%h score=%h exp=13/03", hi, score); errors++; end checks++;
      if (new_record !== 1'b0) begin $display("FAIL nr_record got=%b exp=0", new_record); errors++; end checks++;
      time_up = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pulse(1'b1, 1'b1, 1'b0);
      time_up = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; time_up = 1'b0;
      if (score !== 8'h00 || hi !== 8'h00) begin $display("FAIL rst_mid score=%h hi=%h exp=00/00", score, hi); errors++; end checks++;
      if (busy !== 1'b0 || game_over !== 1'b0 || combo !== 3'd0 || new_record !== 1'b0) begin $display("FAIL rst_mid_flags busy=%b go=%b combo=%0d rec=%b exp=0/0/0/0", busy, game_over, combo, new_record); errors++; end checks++;
      pulse(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (score !== 8'h01) begin $display("FAIL rst_play got=%h exp=01", score); errors++; end checks++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_spaced_catches();
      test_back_to_back();
      test_saturate();
      test_catch_miss();
      test_drain_over();
      test_no_record_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Downstream of the game logic, upstream of the 7-seg decoders.
- Consumes one-cycle catch/miss events and accumulates a two-digit BCD score with a combo bonus.
- Tracks the session high score and sequences play, drain and game-over.
- Drives BCD digits directly, so the decoders need no divide/modulo.

Parameters:
- NORMAL_PTS, 1, points for a normal coin
- GOLD_PTS, 3, points for a gold coin
- BONUS_AT, 5, combo level at which each catch earns +1 extra point
- COMBO_MAX, 7, combo saturation value
- SCORE_MAX, 99, score saturation value (decimal)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state, including high score
- start  in  1  one-cycle pulse; begins a new game from OVER
- time_up  in  1  level from the countdown timer; high means time expired
- catch_evt  in  1  one-cycle pulse; coin caught
- miss_evt  in  1  one-cycle pulse; coin reached the bottom uncaught
- coin_type  in  1  0 = normal, 1 = gold; sampled with catch_evt
- score_tens  out  4  BCD tens digit of the score
- score_ones  out  4  BCD ones digit of the score
- hi_tens  out  4  BCD tens digit of the high score
- hi_ones  out  4  BCD ones digit of the high score
- combo  out  3  current consecutive-catch count
- busy  out  1  high while pending points are non-zero
- game_over  out  1  high in state OVER
- new_record  out  1  high in OVER if the last game set a new high score

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: score 00, hi 00, combo 0, pending 0, busy 0, game_over 0, new_record 0; state PLAY.
- States:
  - PLAY: accepts events. time_up=1 -> DRAIN.
  - DRAIN: ignores events; stays until pending==0, then does the high-score compare -> OVER.
  - OVER: game_over=1; ignores events. start=1 and time_up=0 -> PLAY. start with time_up=1 is ignored.
  - Entering PLAY from OVER clears score, combo, pending and new_record; the high score is kept.
- Catch in PLAY:
  - combo_next = min(combo+1, COMBO_MAX).
  - pts = (coin_type ? GOLD_PTS : NORMAL_PTS) + (combo_next >= BONUS_AT ? 1 : 0).
  - pending <= min(pending + pts, 15) at the same edge.
- Miss in PLAY: combo <= 0.
- Catch and miss in the same cycle:
  - Base points are credited with no bonus.
  - combo <= 0; the miss dominates combo.
- Increment engine: while pending != 0, each cycle pending decrements by 1 and the score increments by 1 in BCD.
  - Ones 9 -> 0 carries into tens.
  - At 99 the score holds; pending still drains.
- Latency: an event at edge k loads pending at edge k. The score changes at edges k+1 .. k+pts.
- A new event while pending is non-zero adds to pending at its edge. An increment and an add in the same cycle net correctly: pending + pts - 1, saturating at 15.
- High-score compare on the DRAIN -> OVER transition:
  - If score > hi: hi <= score and new_record <= 1.
  - Equal or lower: hi is unchanged and new_record = 0.
- busy = (pending != 0), registered-equivalent with pending.
- reset asserted in any state, including mid-drain, overrides all other inputs that cycle.

Decomposition:
- Shared package:
  - State encodings PLAY/DRAIN/OVER (2 bits).
  - BCD digit type (4 bits).
  - Point constants.
- Sub-module bcd2_counter: two-digit BCD incrementer.
  - Inputs: clear, inc.
  - Outputs: tens, ones.
  - Saturates at 99.
  - Instantiated once for the score.
- The high score is a plain register pair; comparison uses the concatenated digits {tens, ones}.

Test Plan:
- Reset, then idle 5 cycles -> score 00, hi 00, combo 0, busy 0, game_over 0.
- 3 normal catches spaced 4 cycles apart -> score 03, combo 3; each increment lands 1 cycle after its event.
- 5 back-to-back normal catches on consecutive cycles:
  - Pending peaks at 5 minus drained; busy stays high.
  - Final score 06 (1+1+1+1+2); combo 5.
- Preload score 98, then a gold catch -> 99 and holds; busy clears after 3 cycles.
- Catch+miss in the same cycle at combo 4 -> +1 only; combo 0.
- Raise time_up with pending=3 and score 10:
  - DRAIN lasts 3 cycles, then OVER with hi 13 and new_record 1.
  - Events during DRAIN/OVER are ignored.
  - start with time_up low -> score 00, hi 13, new_record 0, state PLAY.
